dec_1: RTL and testbench
========================

Name: dec_1

Overview:
- Decoder-side dense layer of the autoencoder. Maps a 6-element latent vector back to 10 outputs: y = W·x + b.
- Uses signed fixed-point arithmetic and ten parallel multiply-accumulate lanes. Processes one latent element per cycle.
- Sits after the encoder path in the Level-3 datapath and is controlled by a start/busy/done handshake.

Parameters:
- BITSIZE, 16, width of every fixed-point word (signed two's complement).
- FRAC, 8, number of fractional bits (default format is Q8.8, so 1.0 = 0x0100).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a computation; sampled only in IDLE.
- x  input  BITSIZE*6  latent vector; element j is x[BITSIZE*j +: BITSIZE].
- w  input  BITSIZE*6*10  static weights; w(j,k) is w[BITSIZE*(j*10+k) +: BITSIZE] (latent j, output k).
- b  input  BITSIZE*10  static bias; b(k) is b[BITSIZE*k +: BITSIZE].
- busy  output  1  high while accumulating.
- done  output  1  one-cycle pulse when y is valid and updated.
- y  output  BITSIZE*10  result vector; element k is y[BITSIZE*k +: BITSIZE]; holds its value until the next done.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- On reset, mid-operation included:
  - state=IDLE, j=0, all 10 accumulators=0, latched x=0.
  - y=0, busy=0, done=0.
  - Any operation in flight is abandoned; no done is produced for it.
- States: IDLE, ACC.
- IDLE, on an edge with start=1:
  - latch x into x_r.
  - acc[k] <= b(k) for all k.
  - j <= 0; go to ACC; busy=1.
  - If done was 1, it is cleared on this edge.
- IDLE, on an edge with start=0: done <= 0; nothing else changes.
- ACC, each edge: acc[k] <= sat(acc[k] + mul(x_r[j], w(j,k))) for all k in parallel; j <= j+1.
- ACC, edge where j==5:
  - y[k] <= sat(acc[k] + mul(x_r[5], w(5,k))); done <= 1.
  - state <= IDLE; busy <= 0; j <= 0.
- Latency: start sampled at edge E0 gives done=1 and a valid y after edge E6 (6 cycles). done stays high for exactly one cycle.
- start while in ACC is ignored; no queueing.
- start in the cycle where done=1 is accepted (the state is IDLE). Back-to-back throughput is one result per 7 cycles.
- x may change after the start edge without effect. w and b are read live and must stay static during ACC.
- Arithmetic:
  - mul: full 2*BITSIZE signed product, arithmetic shift right by FRAC (floor rounding), then saturate to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - sat(add): signed (BITSIZE+1)-bit sum, saturated to the same range.
  - Saturation is applied at every step, so the accumulators never wrap.
- busy is a registered output equal to (state==ACC). y changes only on a done edge or on reset.

Test Plan:
- Bias only: x=all 0, b(k)=k*0x0100, start pulse → done 6 cycles after the start edge; y(k)=k*0x0100; busy high for exactly 6 cycles.
- Uniform MAC: x(j)=0x0100 for all j, w all 0x0080, b=0 → every y(k)=0x0300 (3.0).
- Signed path: x(0)=0xFF00 (-1.0), other x=0, w(0,k)=0x0200, b(k)=0x0100 → every y(k)=0xFF00 (-1.0). Also w(0,k)=0x0080, x(0)=0xFFFF → product floors to 0xFFFF.
- Saturation: x all 0x7F00, w all 0x7F00, b=0 → y=0x7FFF. Then x all 0x8000, w all 0x7F00 → y=0x8000.
- Handshake: start pulsed at cycle 2 of ACC → ignored, single done. Second start asserted in the done cycle with new x → accepted; second done 6 cycles later with the new result; first y held until then.
- Reset mid-op: assert reset at ACC cycle 3 → y=0, busy=0, done=0 immediately. After release, start with the test 2 stimulus → y(k)=0x0300, with no stray done from the aborted run.

Source files
------------

// File: rtl/dec_1.sv
// Decoder dense layer: y = W*x + b over a 6-element latent vector.
// Ten parallel saturating MAC lanes consume one latent element per clock.
module dec_1 #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BITSIZE*6-1:0]    x,
  input  logic [BITSIZE*6*10-1:0] w,
  input  logic [BITSIZE*10-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [BITSIZE*10-1:0]   y
);

  localparam int NIN  = 6;
  localparam int NOUT = 10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  typedef logic signed [BITSIZE-1:0]   word_t;
  typedef logic signed [2*BITSIZE-1:0] wide_t;

  // Clamp a double-width value into the word range.
  function automatic word_t clip(input wide_t v);
    logic [BITSIZE:0] top;
    top = v[2*BITSIZE-1:BITSIZE-1];
    if ((&top) || !(|top))
      clip = v[BITSIZE-1:0];
    else if (v[2*BITSIZE-1])
      clip = {1'b1, {(BITSIZE-1){1'b0}}};
    else
      clip = {1'b0, {(BITSIZE-1){1'b1}}};
  endfunction

  // Full product, floor shift by FRAC, then saturate.
  function automatic word_t mul(input word_t a, input word_t c);
    wide_t p;
    p = $signed({{BITSIZE{a[BITSIZE-1]}}, a}) * $signed({{BITSIZE{c[BITSIZE-1]}}, c});
    mul = clip(p >>> FRAC);
  endfunction

  function automatic word_t sat_add(input word_t a, input word_t c);
    wide_t s;
    s = $signed({{BITSIZE{a[BITSIZE-1]}}, a}) + $signed({{BITSIZE{c[BITSIZE-1]}}, c});
    sat_add = clip(s);
  endfunction

  word_t       x_in [NIN];
  word_t       w_a  [NIN][NOUT];
  word_t       b_a  [NOUT];
  word_t       x_r  [NIN];
  word_t       acc  [NOUT];
  word_t       y_r  [NOUT];
  word_t       nxt  [NOUT];
  logic [0:0]  state;
  logic [2:0]  j;

  for (genvar gj = 0; gj < NIN; gj++) begin : g_in
    assign x_in[gj] = x[BITSIZE*gj +: BITSIZE];
    for (genvar gk = 0; gk < NOUT; gk++) begin : g_w
      assign w_a[gj][gk] = w[BITSIZE*(gj*NOUT+gk) +: BITSIZE];
    end
  end

  for (genvar gk = 0; gk < NOUT; gk++) begin : g_out
    assign b_a[gk] = b[BITSIZE*gk +: BITSIZE];
    assign y[BITSIZE*gk +: BITSIZE] = y_r[gk];
  end

  // MAC stage: next accumulator value for the current latent element.
  always_comb begin
    for (int k = 0; k < NOUT; k++) begin
      nxt[k] = sat_add(acc[k], mul(x_r[j], w_a[j][k]));
    end
  end

  // Control and accumulator registers; reset abandons any run in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      j     <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int k = 0; k < NOUT; k++) begin
        acc[k] <= '0;
        y_r[k] <= '0;
      end
      for (int i = 0; i < NIN; i++) x_r[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < NIN; i++) x_r[i] <= x_in[i];
            for (int k = 0; k < NOUT; k++) acc[k] <= b_a[k];
            j     <= 3'd0;
            state <= ACC;
            busy  <= 1'b1;
          end
        end
        default: begin
          for (int k = 0; k < NOUT; k++) acc[k] <= nxt[k];
          if (j == 3'(NIN-1)) begin
            for (int k = 0; k < NOUT; k++) y_r[k] <= nxt[k];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            j     <= 3'd0;
          end else begin
            j <= j + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_1.sv
// Directed bench for dec_1 with a transaction-level reference model
// checked against the DUT on every falling clock edge.
module tb_dec_1;
  localparam int BW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [BW*6-1:0]   x = '0;
  logic [BW*60-1:0]  w = '0;
  logic [BW*10-1:0]  b = '0;
  logic              busy, done;
  logic [BW*10-1:0]  y;

  int n_chk = 0;
  int n_fail = 0;

  dec_1 #(.BITSIZE(BW), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .w(w), .b(b),
    .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int yk(input int k);
    logic [BW-1:0] v;
    v = y[BW*k +: BW];
    return int'($signed(v));
  endfunction

  function automatic int clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Real-valued product in Q8.8, rounded toward minus infinity.
  function automatic int fmul(input int a, input int c);
    longint p, q;
    p = longint'(a) * longint'(c);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return clamp(q);
  endfunction

  function automatic int field(input logic [BW-1:0] v);
    return int'($signed(v));
  endfunction

  int m_y[10];
  int m_res[10];
  bit m_busy = 0, m_done = 0;
  int m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_busy = 0; m_done = 0;
      for (int k = 0; k < 10; k++) m_y[k] = 0;
    end else if (m_cnt == 0) begin
      m_done = 0;
      if (start) begin
        for (int k = 0; k < 10; k++) begin
          int a;
          a = field(b[BW*k +: BW]);
          for (int jj = 0; jj < 6; jj++)
            a = clamp(longint'(a) + fmul(field(x[BW*jj +: BW]), field(w[BW*(jj*10+k) +: BW])));
          m_res[k] = a;
        end
        m_cnt = 6; m_busy = 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        for (int k = 0; k < 10; k++) m_y[k] = m_res[k];
        m_done = 1; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model busy", int'(busy), int'(m_busy));
    chk("model done", int'(done), int'(m_done));
    for (int k = 0; k < 10; k++) chk($sformatf("model y%0d", k), yk(k), m_y[k]);
  end

  task automatic set_x(input int v0, input int vr);
    for (int jj = 0; jj < 6; jj++) x[BW*jj +: BW] = BW'(jj == 0 ? v0 : vr);
  endtask

  task automatic set_w(input int v0, input int vr);
    for (int jj = 0; jj < 6; jj++)
      for (int k = 0; k < 10; k++) w[BW*(jj*10+k) +: BW] = BW'(jj == 0 ? v0 : vr);
  endtask

  task automatic set_b(input int base, input int step);
    for (int k = 0; k < 10; k++) b[BW*k +: BW] = BW'(base + step*k);
  endtask

  task automatic chk_y(input string name, input int base, input int step);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s y%0d", name, k), yk(k), base + step*k);
  endtask

  // Caller sits just after a rising edge; start is sampled on the next one.
  task automatic run(input string name, input int inject, input int hold_y);
    int busyc, lat;
    bit seen;
    busyc = 0; lat = 0; seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busyc++;
    for (int n = 1; n <= 20 && !seen; n++) begin
      start = (n == inject);
      if (hold_y >= 0 && n == 3) chk({name, " y held"}, yk(4), hold_y);
      @(posedge clk); #1;
      if (done) begin seen = 1; lat = n; end
      else if (busy) busyc++;
    end
    start = 1'b0;
    chk({name, " done seen"}, int'(seen), 1);
    chk({name, " latency"}, lat, 6);
    chk({name, " busy cycles"}, busyc, 6);
  endtask

  initial begin
    set_x(0, 0); set_w(16'h0100, 16'h0100); set_b(0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk_y("reset", 0, 0);

    // Bias only
    set_x(0, 0); set_b(0, 16'h0100);
    run("bias", 0, -1);
    chk_y("bias", 0, 16'h0100);

    // Uniform MAC: 6 * (1.0 * 0.5) = 3.0
    set_x(16'h0100, 16'h0100); set_w(16'h0080, 16'h0080); set_b(0, 0);
    run("uniform", 0, -1);
    chk_y("uniform", 16'h0300, 0);

    // Signed: -1.0 * 2.0 + 1.0 = -1.0
    set_x(-256, 0); set_w(16'h0200, 16'h0200); set_b(16'h0100, 0);
    run("signed", 0, -1);
    chk_y("signed", -256, 0);

    // Floor: -1/256 * 0.5 rounds down to -1/256
    set_x(-1, 0); set_w(16'h0080, 16'h0080); set_b(0, 0);
    run("floor", 0, -1);
    chk_y("floor", -1, 0);

    set_x(16'h7F00, 16'h7F00); set_w(16'h7F00, 16'h7F00);
    run("sat pos", 0, -1);
    chk_y("sat pos", 32767, 0);

    set_x(-32768, -32768);
    run("sat neg", 0, -1);
    chk_y("sat neg", -32768, 0);

    // Ignored start in ACC, then a start accepted in the done cycle
    set_x(16'h0100, 16'h0100); set_w(16'h0080, 16'h0080); set_b(0, 0);
    run("ignored", 2, -1);
    chk_y("ignored", 16'h0300, 0);
    set_x(16'h0200, 16'h0200);
    run("b2b", 0, 16'h0300);
    chk_y("b2b", 16'h0600, 0);

    // Reset in the middle of accumulation
    set_x(16'h0100, 16'h0100);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk_y("abort", 0, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      chk("no stray done", int'(done), 0);
    end
    run("after reset", 0, 0);
    chk_y("after reset", 16'h0300, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
